commit_trace_buffer: RTL and testbench

- Synthesizable commit-trace capture unit for the beaver32rv core family.
- Sits beside the processor and snoops its per-instruction commit signals: PC, instruction, register writeback and data-memory write.
- Stores commit records in a parametrised FIFO and exposes them through a valid/ready readout port.
- Tracks a cycle count and detects two end conditions: self-loop halt and cycle-limit timeout. This lets hardware runs and benches check results without a free-running text monitor.

---
 rtl/commit_trace_buffer.sv | 180 ++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture unit: snoops per-instruction commit signals into a FWFT FIFO
// and flags self-loop halt or cycle-limit timeout.
module commit_trace_buffer #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int CYCLE_LIMIT = 7800,
    parameter int OVERWRITE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     commit_valid,
    input  logic [XLEN-1:0]          pc_addr,
    input  logic [31:0]              instruction,
    input  logic                     reg_write,
    input  logic [4:0]               rd_addr,
    input  logic [XLEN-1:0]          rd_data,
    input  logic                     mem_write,
    input  logic [XLEN-1:0]          mem_addr,
    input  logic [XLEN-1:0]          mem_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_cycle,
    output logic [XLEN-1:0]          trace_pc,
    output logic [31:0]              trace_instr,
    output logic                     trace_rd_we,
    output logic [4:0]               trace_rd_addr,
    output logic [XLEN-1:0]          trace_rd_data,
    output logic                     trace_mem_we,
    output logic [XLEN-1:0]          trace_mem_addr,
    output logic [XLEN-1:0]          trace_mem_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              lost,
    output logic [31:0]              cycle,
    output logic                     halted,
    output logic                     timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_TIMEOUT} state_t;

    typedef struct packed {
        logic [31:0]     cycle;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            rd_we;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_data;
        logic            mem_we;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
    } rec_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     lost_q, lost_d;
    logic [31:0]     cycle_q, cycle_d;
    logic [XLEN-1:0] prev_pc_q, prev_pc_d;

    rec_t            fifo_q [DEPTH];
    rec_t            push_rec;
    rec_t            head;

    logic            in_run;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            halt_hit;
    logic            cycle_hit;

    always_comb begin
        in_run    = (state_q == S_RUN);
        push      = in_run && commit_valid;
        pop       = (count_q != '0) && trace_ready;
        full      = (count_q == CW'(DEPTH));
        halt_hit  = push && (instruction == 32'h0000_006F) && (pc_addr == prev_pc_q);
        cycle_hit = (cycle_q == 32'(CYCLE_LIMIT - 1));
        // When full without a pop, only overwrite mode lets the new record in.
        wr_en     = push && (!full || pop || (OVERWRITE != 0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN: begin
                if (halt_hit)       state_d = S_HALTED;
                else if (cycle_hit) state_d = S_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        halted  = (state_q == S_HALTED);
        timeout = (state_q == S_TIMEOUT);
    end

    always_comb begin
        push_rec.cycle    = cycle_q;
        push_rec.pc       = pc_addr;
        push_rec.instr    = instruction;
        push_rec.rd_we    = reg_write && (rd_addr != 5'd0);
        push_rec.rd_addr  = rd_addr;
        push_rec.rd_data  = rd_data;
        push_rec.mem_we   = mem_write;
        push_rec.mem_addr = mem_addr;
        push_rec.mem_data = mem_data;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        lost_d    = lost_q;
        cycle_d   = cycle_q;
        prev_pc_d = prev_pc_q;
        if (in_run) cycle_d = cycle_q + 32'd1;
        if (push) prev_pc_d = pc_addr;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        // Overwrite on a full FIFO retires the oldest entry just like a pop.
        if (pop || (wr_en && full && !pop)) rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_en && !pop && !full)    count_d = count_q + CW'(1);
        else if (pop && !wr_en)        count_d = count_q - CW'(1);
        if (push && full && !pop && (lost_q != 16'hFFFF)) lost_d = lost_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            lost_q    <= '0;
            cycle_q   <= '0;
            prev_pc_q <= XLEN'(1);
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            lost_q    <= lost_d;
            cycle_q   <= cycle_d;
            prev_pc_q <= prev_pc_d;
        end
    end

    // Record storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr_en) fifo_q[wr_ptr_q] <= push_rec;
    end

    always_comb begin
        head           = fifo_q[rd_ptr_q];
        trace_valid    = (count_q != '0);
        trace_cycle    = trace_valid ? head.cycle    : '0;
        trace_pc       = trace_valid ? head.pc       : '0;
        trace_instr    = trace_valid ? head.instr    : '0;
        trace_rd_we    = trace_valid ? head.rd_we    : 1'b0;
        trace_rd_addr  = trace_valid ? head.rd_addr  : '0;
        trace_rd_data  = trace_valid ? head.rd_data  : '0;
        trace_mem_we   = trace_valid ? head.mem_we   : 1'b0;
        trace_mem_addr = trace_valid ? head.mem_addr : '0;
        trace_mem_data = trace_valid ? head.mem_data : '0;
        count          = count_q;
        lost           = lost_q;
        cycle          = cycle_q;
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: table-driven commits checked through a FIFO scoreboard,
// plus overwrite, halt, timeout and asynchronous-reset sequences.
module tb_commit_trace_buffer;
    localparam int XL   = 32;
    localparam int DP   = 4;
    localparam int LIM  = 1000;
    localparam int TLIM = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0, commit_valid = 1'b0, reg_write = 1'b0, mem_write = 1'b0;
    logic        trace_ready = 1'b0;
    logic [31:0] pc_addr = '0, instruction = '0, rd_data = '0, mem_addr = '0, mem_data = '0;
    logic [4:0]  rd_addr = '0;

    logic        t_valid, t_rd_we, t_mem_we, halted, timeout;
    logic [31:0] t_cycle, t_pc, t_instr, t_rd_data, t_mem_addr, t_mem_data, cycle;
    logic [4:0]  t_rd_addr;
    logic [2:0]  count;
    logic [15:0] lost;

    logic        o_valid, o_rd_we, o_mem_we, o_halted, o_timeout;
    logic [31:0] o_cycle, o_pc, o_instr, o_rd_data, o_mem_addr, o_mem_data, o_cyc;
    logic [4:0]  o_rd_addr;
    logic [2:0]  o_count;
    logic [15:0] o_lost;

    logic        x_valid, x_rd_we, x_mem_we, x_halted, x_timeout;
    logic [31:0] x_cycle, x_pc, x_instr, x_rd_data, x_mem_addr, x_mem_data, x_cyc;
    logic [4:0]  x_rd_addr;
    logic [2:0]  x_count;
    logic [15:0] x_lost;

    always #5 clk = ~clk;

    commit_trace_buffer #(.XLEN(XL), .DEPTH(DP), .CYCLE_LIMIT(LIM), .OVERWRITE(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .commit_valid(commit_valid),
        .pc_addr(pc_addr), .instruction(instruction), .reg_write(reg_write),
        .rd_addr(rd_addr), .rd_data(rd_data), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data), .trace_valid(t_valid),
        .trace_ready(trace_ready), .trace_cycle(t_cycle), .trace_pc(t_pc),
        .trace_instr(t_instr), .trace_rd_we(t_rd_we), .trace_rd_addr(t_rd_addr),
        .trace_rd_data(t_rd_data), .trace_mem_we(t_mem_we), .trace_mem_addr(t_mem_addr),
        .trace_mem_data(t_mem_data), .count(count), .lost(lost), .cycle(cycle),
        .halted(halted), .timeout(timeout));

    commit_trace_buffer #(.XLEN(XL), .DEPTH(DP), .CYCLE_LIMIT(LIM), .OVERWRITE(1)) dut_ow (
        .clk(clk), .rst(rst), .enable(enable), .commit_valid(commit_valid),
        .pc_addr(pc_addr), .instruction(instruction), .reg_write(reg_write),
        .rd_addr(rd_addr), .rd_data(rd_data), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data), .trace_valid(o_valid),
        .trace_ready(trace_ready), .trace_cycle(o_cycle), .trace_pc(o_pc),
        .trace_instr(o_instr), .trace_rd_we(o_rd_we), .trace_rd_addr(o_rd_addr),
        .trace_rd_data(o_rd_data), .trace_mem_we(o_mem_we), .trace_mem_addr(o_mem_addr),
        .trace_mem_data(o_mem_data), .count(o_count), .lost(o_lost), .cycle(o_cyc),
        .halted(o_halted), .timeout(o_timeout));

    commit_trace_buffer #(.XLEN(XL), .DEPTH(DP), .CYCLE_LIMIT(TLIM), .OVERWRITE(0)) dut_to (
        .clk(clk), .rst(rst), .enable(enable), .commit_valid(commit_valid),
        .pc_addr(pc_addr), .instruction(instruction), .reg_write(reg_write),
        .rd_addr(rd_addr), .rd_data(rd_data), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data), .trace_valid(x_valid),
        .trace_ready(trace_ready), .trace_cycle(x_cycle), .trace_pc(x_pc),
        .trace_instr(x_instr), .trace_rd_we(x_rd_we), .trace_rd_addr(x_rd_addr),
        .trace_rd_data(x_rd_data), .trace_mem_we(x_mem_we), .trace_mem_addr(x_mem_addr),
        .trace_mem_data(x_mem_data), .count(x_count), .lost(x_lost), .cycle(x_cyc),
        .halted(x_halted), .timeout(x_timeout));

    typedef struct {
        logic [31:0] cyc, pc, instr;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] rdd;
        logic        mw;
        logic [31:0] ma, md;
    } rec_t;

    typedef struct {
        logic        en, cv;
        logic [31:0] pc, instr;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] rdd;
        logic        mw;
        logic [31:0] ma, md;
        logic        ready;
        logic        exp_we;
    } vec_t;

    vec_t        tbl [0:20];
    rec_t        mq [$];
    int          m_state;
    logic [31:0] m_cycle, m_prev;
    int          m_lost, run_edges, n_chk, n_fail, step_no;
    logic [31:0] saved_cycle;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic cv, input logic [31:0] pc, input logic [31:0] instr,
                                input logic rw, input logic [4:0] rd, input logic [31:0] rdd,
                                input logic mw, input logic [31:0] ma, input logic [31:0] md,
                                input logic rdy, input logic we);
        vec_t v;
        v.en = 1'b0; v.cv = cv; v.pc = pc; v.instr = instr; v.rw = rw; v.rd = rd;
        v.rdd = rdd; v.mw = mw; v.ma = ma; v.md = md; v.ready = rdy; v.exp_we = we;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_state = 0; m_cycle = 0; m_prev = 32'h1; m_lost = 0; run_edges = 0;
    endtask

    task automatic step(input vec_t v);
        logic mpop, push;
        rec_t r;
        enable = v.en; commit_valid = v.cv; pc_addr = v.pc; instruction = v.instr;
        reg_write = v.rw; rd_addr = v.rd; rd_data = v.rdd; mem_write = v.mw;
        mem_addr = v.ma; mem_data = v.md; trace_ready = v.ready;
        #1;
        chk("trace_valid", t_valid, mq.size() != 0);
        mpop = (mq.size() != 0) && v.ready;
        if (mpop) begin
            chk("pop_cycle", t_cycle, mq[0].cyc);
            chk("pop_pc", t_pc, mq[0].pc);
            chk("pop_instr", t_instr, mq[0].instr);
            chk("pop_rd_we", t_rd_we, mq[0].rd_we);
            chk("pop_rd_addr", t_rd_addr, mq[0].rd);
            chk("pop_rd_data", t_rd_data, mq[0].rdd);
            chk("pop_mem_we", t_mem_we, mq[0].mw);
            chk("pop_mem_addr", t_mem_addr, mq[0].ma);
            chk("pop_mem_data", t_mem_data, mq[0].md);
            void'(mq.pop_front());
        end
        push = (m_state == 1) && v.cv;
        if (m_state != 0) run_edges++;
        if (push) begin
            r = '{m_cycle, v.pc, v.instr, v.exp_we, v.rd, v.rdd, v.mw, v.ma, v.md};
            if (mq.size() < DP) mq.push_back(r);
            else m_lost++;
        end
        if (m_state == 0) begin
            if (v.en) m_state = 1;
        end else if (m_state == 1) begin
            if (push && v.instr == 32'h6F && v.pc == m_prev) m_state = 2;
            else if (m_cycle == LIM - 1) m_state = 3;
            m_cycle = m_cycle + 1;
        end
        if (push) m_prev = v.pc;
        @(posedge clk);
        #1;
        chk("count", count, mq.size());
        chk("lost", lost, m_lost);
        chk("cycle", cycle, m_cycle);
        chk("halted", halted, m_state == 2);
        chk("timeout", timeout, m_state == 3);
        chk("to_timeout", x_timeout, run_edges >= TLIM);
        chk("to_cycle", x_cyc, (run_edges < TLIM) ? run_edges : TLIM);
        chk("to_halted", x_halted, 1'b0);
        $display("step %0d en=%0d cv=%0d pc=%h rdy=%0d -> count=%0d lost=%0d cycle=%0d halted=%0d",
                 step_no, v.en, v.cv, v.pc, v.ready, count, lost, cycle, halted);
        step_no++;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, t_valid, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_lost"}, lost, 0);
        chk({tag, "_cycle"}, cycle, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_tpc"}, t_pc, 0);
        chk({tag, "_tcycle"}, t_cycle, 0);
        chk({tag, "_tinstr"}, t_instr, 0);
        chk({tag, "_trd"}, {t_rd_we, t_rd_addr, t_rd_data}, 0);
        chk({tag, "_tmem"}, {t_mem_we, t_mem_addr, t_mem_data}, 0);
    endtask

    initial begin
        vec_t v;
        n_chk = 0; n_fail = 0; step_no = 0;
        model_reset();

        tbl[0] = mk(1, 32'h0,  32'h00500293, 1, 5, 32'h11, 0, 0, 0, 0, 1);
        tbl[1] = mk(1, 32'h4,  32'h00128293, 1, 5, 32'h12, 0, 0, 0, 0, 1);
        tbl[2] = mk(1, 32'h8,  32'h00128293, 1, 5, 32'h13, 0, 0, 0, 0, 1);
        tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[4] = mk(1, 32'h10, 32'h02a02423, 1, 0, 32'h55, 1, 32'd8, 32'd42, 1, 0);
        for (int i = 5; i < 8; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 6; k++)
            tbl[8+k] = mk(1, 32'h100 + 32'(4*k), 32'h13, (k % 2) == 1, 5'(k+1),
                          32'hA0 + 32'(k), 0, 0, 0, 0, (k % 2) == 1);
        tbl[14] = mk(1, 32'h200, 32'h13, 0, 0, 0, 1, 32'h40, 32'h99, 1, 0);
        for (int i = 15; i < 19; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[19] = mk(1, 32'h300, 32'h13, 1, 3, 32'h77, 0, 0, 0, 1, 1);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        @(posedge clk);
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Commit while IDLE, then the enabling edge: neither is captured.
        step(mk(1, 32'h900, 32'h13, 1, 1, 1, 0, 0, 0, 0, 1));
        v = mk(1, 32'h904, 32'h13, 1, 1, 1, 0, 0, 0, 0, 1);
        v.en = 1'b1;
        step(v);

        for (int i = 0; i < 14; i++) step(tbl[i]);
        chk("drop_head_pc", t_pc, 32'h100);
        chk("ow_count", o_count, 4);
        chk("ow_lost", o_lost, 2);
        chk("ow_head_pc", o_pc, 32'h108);

        step(tbl[14]);
        chk("ow_pp_count", o_count, 4);
        chk("ow_pp_lost", o_lost, 2);
        chk("ow_pp_head", o_pc, 32'h10C);

        for (int i = 15; i < 21; i++) step(tbl[i]);

        step(mk(1, 32'd12, 32'h6F, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("halt_early", halted, 0);
        step(mk(1, 32'd12, 32'h6F, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("halt_set", halted, 1);
        saved_cycle = cycle;
        step(mk(1, 32'h40, 32'h13, 1, 1, 1, 0, 0, 0, 0, 1));
        step(mk(1, 32'h44, 32'h13, 1, 1, 1, 0, 0, 0, 0, 1));
        chk("halt_frozen", cycle, saved_cycle);
        chk("halt_count", count, 2);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.en = 1'b1;
        step(v);
        step(mk(1, 32'h500, 32'h13, 1, 2, 32'h5, 0, 0, 0, 0, 1));
        step(mk(1, 32'h504, 32'h13, 0, 0, 0, 1, 32'h80, 32'h6, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        chk_zero("midrun_rst");
        chk("midrun_ow_count", o_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
